// File: rtl/nf_ahb_pkg.sv
// nf_ahb_pkg: nanoFOX AHB-Lite constants, default-slave states and the default address map
package nf_ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;
  localparam logic [1:0] HRESP_OKAY    = 2'd0;
  localparam logic [1:0] HRESP_ERROR   = 2'd1;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;
  typedef enum logic [1:0] {TO_IDLE, TO_ERR1, TO_ERR2} to_state_t;
  // RAM, GPIO, PWM, UART on 64 KiB boundaries
  localparam logic [3:0][31:0] AHB_BASE_DEF = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [3:0][31:0] AHB_MASK_DEF = {4{32'hFFFF_0000}};
  function automatic logic trans_active(logic [1:0] t);
    return t == HTRANS_NONSEQ || t == HTRANS_SEQ;
  endfunction
endpackage

// File: rtl/nf_ahb_router_gen_if.sv
// nf_ahb_router_gen_if: master-side bus plus broadcast/response arrays towards the slaves
interface nf_ahb_router_gen_if #(
  parameter int slave_c = 4
);
  logic [31:0]              haddr, hwdata, hrdata;
  logic                     hwrite, hready, hto_flag;
  logic [1:0]               htrans, hresp;
  logic [2:0]               hsize, hburst;
  logic [slave_c-1:0][31:0] haddr_s, hwdata_s, hrdata_s;
  logic [slave_c-1:0]       hwrite_s, hready_s, hsel_s, hreadyin_s;
  logic [slave_c-1:0][1:0]  htrans_s, hresp_s;
  logic [slave_c-1:0][2:0]  hsize_s, hburst_s;
  modport master (
    output haddr, hwdata, hwrite, htrans, hsize, hburst, hrdata_s, hresp_s, hready_s,
    input  hrdata, hresp, hready, haddr_s, hwdata_s, hwrite_s, htrans_s, hsize_s, hburst_s,
    input  hsel_s, hreadyin_s, hto_flag
  );
  modport slave (
    input  haddr, hwdata, hwrite, htrans, hsize, hburst, hrdata_s, hresp_s, hready_s,
    output hrdata, hresp, hready, haddr_s, hwdata_s, hwrite_s, htrans_s, hsize_s, hburst_s,
    output hsel_s, hreadyin_s, hto_flag
  );
endinterface

// File: rtl/nf_ahb_dflt_slave.sv
// nf_ahb_dflt_slave: two-cycle ERROR responder for unmapped transfers
// Watchdog override sequencer present only with NF_AHB_ROUTER_TIMEOUT_EN.
module nf_ahb_dflt_slave
  import nf_ahb_pkg::*;
#(
  parameter int timeout_c = 255
) (
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       i_hready,
  input  logic       i_unm_act,
  input  logic       i_stall,
  output logic       o_ds_ready,
  output logic [1:0] o_ds_resp,
  output logic       o_to_act,
  output logic       o_to_ready,
  output logic       o_to_flag
);
  ds_state_t  r_ds;
  logic       r_ds_ready;
  logic [1:0] r_ds_resp;
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_ds       <= DS_IDLE;
      r_ds_ready <= 1'b1;
      r_ds_resp  <= HRESP_OKAY;
    end else if (r_ds == DS_ERR1) begin
      r_ds       <= DS_ERR2;
      r_ds_ready <= 1'b1;
      r_ds_resp  <= HRESP_ERROR;
    end else if (i_hready && i_unm_act) begin
      r_ds       <= DS_ERR1;
      r_ds_ready <= 1'b0;
      r_ds_resp  <= HRESP_ERROR;
    end else begin
      r_ds       <= DS_IDLE;
      r_ds_ready <= 1'b1;
      r_ds_resp  <= HRESP_OKAY;
    end
  end
  assign o_ds_ready = r_ds_ready;
  assign o_ds_resp  = r_ds_resp;
`ifdef NF_AHB_ROUTER_TIMEOUT_EN
  to_state_t   r_to;
  logic [15:0] r_cnt;
  logic        r_to_act, r_to_ready, r_to_flag;
  // the counter is held at zero while the override owns the bus
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_to       <= TO_IDLE;
      r_cnt      <= '0;
      r_to_act   <= 1'b0;
      r_to_ready <= 1'b1;
      r_to_flag  <= 1'b0;
    end else begin
      r_cnt <= (i_stall && r_to == TO_IDLE) ? r_cnt + 16'd1 : '0;
      if (r_to == TO_ERR1) begin
        r_to       <= TO_ERR2;
        r_to_act   <= 1'b1;
        r_to_ready <= 1'b1;
      end else if (r_to == TO_IDLE && i_stall && r_cnt == 16'(timeout_c - 1)) begin
        r_to       <= TO_ERR1;
        r_to_act   <= 1'b1;
        r_to_ready <= 1'b0;
        r_to_flag  <= 1'b1;
      end else begin
        r_to       <= TO_IDLE;
        r_to_act   <= 1'b0;
        r_to_ready <= 1'b1;
      end
    end
  end
  assign o_to_act   = r_to_act;
  assign o_to_ready = r_to_ready;
  assign o_to_flag  = r_to_flag;
`else
  logic w_unused;
  assign w_unused   = ^{i_stall, 16'(timeout_c)};
  assign o_to_act   = 1'b0;
  assign o_to_ready = 1'b1;
  assign o_to_flag  = 1'b0;
`endif
endmodule

// File: rtl/nf_ahb_router_gen.sv
// nf_ahb_router_gen: AHB-Lite one-master to slave_c-slave router with default ERROR slave
// Optional wait-state watchdog enabled by NF_AHB_ROUTER_TIMEOUT_EN.
`ifndef SLAVE_COUNT
`define SLAVE_COUNT 4
`endif
module nf_ahb_router_gen
  import nf_ahb_pkg::*;
#(
  parameter int                       slave_c   = `SLAVE_COUNT,
  parameter logic [slave_c-1:0][31:0] ahb_base  = AHB_BASE_DEF,
  parameter logic [slave_c-1:0][31:0] ahb_mask  = AHB_MASK_DEF,
  parameter int                       timeout_c = 255
) (
  input logic                hclk,
  input logic                hresetn,
  nf_ahb_router_gen_if.slave bus
);
  logic [slave_c-1:0] w_hit, w_hsel;
  logic [slave_c:0]   w_sel_ap, r_sel_dp;
  logic               w_ds, w_hready, w_sel_rdy, w_ds_ready, w_to_act, w_to_ready, w_stall;
  logic [1:0]         w_hresp, w_sel_resp, w_ds_resp;
  logic [31:0]        w_sel_rdata;
  for (genvar i = 0; i < slave_c; i++) begin : g_hit
    assign w_hit[i] = (bus.haddr & ahb_mask[i]) == ahb_base[i];
  end
  // lowest set bit wins on overlapping regions; top bit of the select is the default slave
  assign w_hsel   = w_hit & -w_hit;
  assign w_sel_ap = {~|w_hit, w_hsel};
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_sel_dp <= '0;
    else if (w_hready) r_sel_dp <= w_sel_ap;
  end
  always_comb begin
    w_sel_rdata = '0;
    w_sel_resp  = HRESP_OKAY;
    w_sel_rdy   = 1'b1;
    for (int i = 0; i < slave_c; i++)
      if (r_sel_dp[i]) begin
        w_sel_rdata = bus.hrdata_s[i];
        w_sel_resp  = bus.hresp_s[i];
        w_sel_rdy   = bus.hready_s[i];
      end
  end
  assign w_ds     = r_sel_dp[slave_c];
  assign w_stall  = |(r_sel_dp[slave_c-1:0] & ~bus.hready_s);
  assign w_hready = w_to_act ? w_to_ready : w_ds ? w_ds_ready : w_sel_rdy;
  assign w_hresp  = w_to_act ? HRESP_ERROR : w_ds ? w_ds_resp : w_sel_resp;
  nf_ahb_dflt_slave #(.timeout_c(timeout_c)) u_dflt (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .i_hready   (w_hready),
    .i_unm_act  (~|w_hit & trans_active(bus.htrans)),
    .i_stall    (w_stall),
    .o_ds_ready (w_ds_ready),
    .o_ds_resp  (w_ds_resp),
    .o_to_act   (w_to_act),
    .o_to_ready (w_to_ready),
    .o_to_flag  (bus.hto_flag)
  );
  assign bus.hready     = w_hready;
  assign bus.hresp      = w_hresp;
  assign bus.hrdata     = (w_ds | w_to_act) ? '0 : w_sel_rdata;
  assign bus.hsel_s     = w_hsel;
  assign bus.hreadyin_s = {slave_c{w_hready}};
  assign bus.haddr_s    = {slave_c{bus.haddr}};
  assign bus.hwdata_s   = {slave_c{bus.hwdata}};
  assign bus.hwrite_s   = {slave_c{bus.hwrite}};
  assign bus.htrans_s   = {slave_c{bus.htrans}};
  assign bus.hsize_s    = {slave_c{bus.hsize}};
  assign bus.hburst_s   = {slave_c{bus.hburst}};
endmodule

// File: tb/tb_nf_ahb_router_gen.sv
// tb_nf_ahb_router_gen: decode table, directed corner sequences and a randomized model comparison
module tb_nf_ahb_router_gen;
  logic hclk = 1'b0;
  logic hresetn;
  int   total = 0;
  int   bad = 0;
  int   owner, err_left, wait_run;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  hsel;
    logic [31:0] rdata;
  } vec_t;
  vec_t vt[8];
  nf_ahb_router_gen_if #(.slave_c(4)) bus ();
  nf_ahb_router_gen #(.slave_c(4), .timeout_c(8)) dut (.hclk(hclk), .hresetn(hresetn), .bus(bus));
  always #5 hclk = ~hclk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic resp(string nm, logic r, logic [1:0] s, logic [31:0] d);
    chk({nm, ".hready"}, 32'(r), 32'(bus.hready));
    chk({nm, ".hresp"}, 32'(bus.hresp), 32'(s));
    chk({nm, ".hrdata"}, bus.hrdata, d);
  endtask
  task automatic cyc();
    @(posedge hclk);
    #2;
  endtask
  task automatic drive(logic [31:0] a, logic [1:0] t, logic w);
    bus.haddr  = a;
    bus.htrans = t;
    bus.hwrite = w;
    bus.hwdata = ~a;
  endtask
  function automatic int dec(logic [31:0] a);
    return (a[31:18] == 14'd0) ? int'(a[17:16]) : 4;
  endfunction
  initial begin
    logic [31:0] a;
    logic [1:0]  t;
    logic        e_r;
    logic [1:0]  e_s;
    logic [31:0] e_d;
    logic [3:0]  e_sel;
    int          p;
    hresetn = 1'b0;
    drive(32'h0002_0000, 2'd0, 1'b0);
    bus.hsize    = 3'd2;
    bus.hburst   = 3'd0;
    bus.hready_s = '1;
    bus.hresp_s  = '0;
    for (int i = 0; i < 4; i++) bus.hrdata_s[i] = 32'hCAFE_0000 + 32'(i);
    #3;
    resp("reset", 1'b1, 2'd0, 32'h0);
    chk("reset.hsel", 32'(bus.hsel_s), 32'h4);
    chk("reset.flag", 32'(bus.hto_flag), 32'h0);
    drive(32'h0005_0000, 2'd0, 1'b0);
    #1;
    chk("reset.hsel_unm", 32'(bus.hsel_s), 32'h0);
    cyc();
    cyc();
    hresetn = 1'b1;
    vt[0] = '{32'h0000_0000, 4'b0001, 32'h0};
    vt[1] = '{32'h0001_0004, 4'b0010, 32'hCAFE_0000};
    vt[2] = '{32'h0002_FFFC, 4'b0100, 32'hCAFE_0001};
    vt[3] = '{32'h0003_0000, 4'b1000, 32'hCAFE_0002};
    vt[4] = '{32'h0005_0000, 4'b0000, 32'hCAFE_0003};
    vt[5] = '{32'hFFFF_0000, 4'b0000, 32'h0};
    vt[6] = '{32'h0000_FFFF, 4'b0001, 32'h0};
    vt[7] = '{32'h0004_0000, 4'b0000, 32'hCAFE_0000};
    for (int k = 0; k < 8; k++) begin
      cyc();
      drive(vt[k].addr, 2'd0, 1'b0);
      #1;
      chk("tbl.hsel", 32'(bus.hsel_s), 32'(vt[k].hsel));
      chk("tbl.haddr_s", bus.haddr_s[3], vt[k].addr);
      resp("tbl", 1'b1, 2'd0, vt[k].rdata);
    end
    cyc();
    drive(32'h0001_0004, 2'd2, 1'b1);
    #1;
    chk("ws.hsel", 32'(bus.hsel_s), 32'h2);
    resp("ws.addr", 1'b1, 2'd0, 32'h0);
    cyc();
    drive(32'h0, 2'd0, 1'b0);
    bus.hready_s[1] = 1'b0;
    #1;
    resp("ws.w1", 1'b0, 2'd0, 32'hCAFE_0001);
    chk("ws.hreadyin", 32'(bus.hreadyin_s), 32'h0);
    for (int k = 2; k <= 3; k++) begin
      cyc();
      #1;
      resp("ws.wn", 1'b0, 2'd0, 32'hCAFE_0001);
    end
    cyc();
    bus.hready_s[1] = 1'b1;
    drive(32'h0005_0000, 2'd2, 1'b0);
    #1;
    resp("ws.end", 1'b1, 2'd0, 32'hCAFE_0001);
    chk("ws.hreadyin_end", 32'(bus.hreadyin_s), 32'hF);
    chk("unm.hsel", 32'(bus.hsel_s), 32'h0);
    cyc();
    drive(32'h0, 2'd0, 1'b0);
    #1;
    resp("unm.err1", 1'b0, 2'd1, 32'h0);
    cyc();
    drive(32'h0006_0000, 2'd2, 1'b0);
    #1;
    resp("unm.err2", 1'b1, 2'd1, 32'h0);
    cyc();
    drive(32'h0000_0010, 2'd2, 1'b0);
    #1;
    resp("b2b.err1", 1'b0, 2'd1, 32'h0);
    cyc();
    #1;
    resp("b2b.err2", 1'b1, 2'd1, 32'h0);
    chk("b2b.hsel", 32'(bus.hsel_s), 32'h1);
    cyc();
    drive(32'h0005_0000, 2'd0, 1'b0);
    #1;
    resp("b2b.ram", 1'b1, 2'd0, 32'hCAFE_0000);
    cyc();
    drive(32'h0, 2'd0, 1'b0);
    #1;
    resp("unm_idle", 1'b1, 2'd0, 32'h0);
    cyc();
    #1;
    resp("unm_idle.next", 1'b1, 2'd0, 32'hCAFE_0000);
    cyc();
    drive(32'h0002_0000, 2'd2, 1'b0);
    #1;
    chk("stall.hsel", 32'(bus.hsel_s), 32'h4);
    cyc();
    drive(32'h0, 2'd0, 1'b0);
    bus.hready_s[2] = 1'b0;
    #1;
    resp("stall.w1", 1'b0, 2'd0, 32'hCAFE_0002);
`ifdef NF_AHB_ROUTER_TIMEOUT_EN
    for (int k = 2; k <= 8; k++) begin
      cyc();
      #1;
      resp("wd.wait", 1'b0, 2'd0, 32'hCAFE_0002);
    end
    cyc();
    #1;
    chk("wd.err1.hready", 32'(bus.hready), 32'h0);
    chk("wd.err1.hresp", 32'(bus.hresp), 32'h1);
    chk("wd.err1.hreadyin", 32'(bus.hreadyin_s), 32'h0);
    chk("wd.flag", 32'(bus.hto_flag), 32'h1);
    cyc();
    #1;
    chk("wd.err2.hready", 32'(bus.hready), 32'h1);
    chk("wd.err2.hresp", 32'(bus.hresp), 32'h1);
    chk("wd.err2.hreadyin", 32'(bus.hreadyin_s), 32'hF);
    cyc();
    #1;
    resp("wd.after", 1'b1, 2'd0, 32'hCAFE_0000);
    chk("wd.flag_sticky", 32'(bus.hto_flag), 32'h1);
`else
    for (int k = 2; k <= 12; k++) begin
      cyc();
      #1;
      resp("stall.wait", 1'b0, 2'd0, 32'hCAFE_0002);
    end
    chk("stall.flag", 32'(bus.hto_flag), 32'h0);
    cyc();
    bus.hready_s[2] = 1'b1;
    #1;
    resp("stall.end", 1'b1, 2'd0, 32'hCAFE_0002);
`endif
    bus.hready_s[2] = 1'b1;
    cyc();
    drive(32'h0001_0000, 2'd2, 1'b1);
    #1;
    cyc();
    drive(32'h0, 2'd0, 1'b0);
    bus.hready_s[1] = 1'b0;
    #1;
    chk("rst_mid.pre", 32'(bus.hready), 32'h0);
    #2;
    hresetn = 1'b0;
    #1;
    resp("rst_mid", 1'b1, 2'd0, 32'h0);
    chk("rst_mid.flag", 32'(bus.hto_flag), 32'h0);
    drive(32'h0003_0000, 2'd0, 1'b0);
    #1;
    chk("rst_mid.hsel", 32'(bus.hsel_s), 32'h8);
    cyc();
    bus.hready_s = '1;
    drive(32'h0, 2'd0, 1'b0);
    hresetn = 1'b1;
    owner    = dec(bus.haddr);
    err_left = 0;
    wait_run = 0;
    for (int n = 0; n < 400; n++) begin
      cyc();
      p = int'($urandom_range(0, 5));
      a = (p < 4) ? {14'd0, 2'(p), 16'($urandom)} :
          (p == 4) ? (32'h0004_0000 | ($urandom & 32'h000F_FFFF)) : ($urandom | 32'h8000_0000);
      t = 2'($urandom_range(0, 3));
      drive(a, t, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 4; i++) bus.hready_s[i] = ($urandom_range(0, 3) != 0);
      if (wait_run >= 5) bus.hready_s = '1;
      #1;
      e_sel = (dec(a) < 4) ? 4'(1 << dec(a)) : 4'h0;
      if (owner == 4) begin
        e_r = (err_left != 2);
        e_s = (err_left > 0) ? 2'd1 : 2'd0;
        e_d = 32'h0;
      end else if (owner >= 0) begin
        e_r = bus.hready_s[owner];
        e_s = 2'd0;
        e_d = 32'hCAFE_0000 + 32'(owner);
      end else begin
        e_r = 1'b1;
        e_s = 2'd0;
        e_d = 32'h0;
      end
      chk("rnd.hsel", 32'(bus.hsel_s), 32'(e_sel));
      resp("rnd", e_r, e_s, e_d);
      wait_run = (owner >= 0 && owner < 4 && !e_r) ? wait_run + 1 : 0;
      if (e_r) begin
        owner    = dec(a);
        err_left = (owner == 4 && t[1]) ? 2 : 0;
      end else if (err_left == 2) err_left = 1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nf_ahb_router_gen.md
# nf_ahb_router_gen

Parametrised AHB-Lite router for the nanoFOX bus: one master port fanned out to `slave_c` slaves through a parameter-driven base/mask address map. It adds three things to the basic address-decode router:
- a built-in default slave that returns the two-cycle AHB ERROR response for unmapped transfers;
- a data-phase select register that honours wait states;
- an optional wait-state watchdog.

It sits between the core's AHB master and the memory/peripheral slaves.

## Interface
Parameters:
- `slave_c`, `` `SLAVE_COUNT ``: number of slaves (1..16).
- `ahb_base`, `nf_ahb_pkg::AHB_BASE_DEF`: `[slave_c-1:0][31:0]` slave base addresses.
- `ahb_mask`, `nf_ahb_pkg::AHB_MASK_DEF`: `[slave_c-1:0][31:0]` slave address masks.
- `timeout_c`, 255: watchdog limit in wait cycles (1..65535); used only with the macro.

Ports:
- `hclk` in 1: clock. One clock; all state on the rising edge.
- `hresetn` in 1: reset, asynchronous, active-low.
- Master-side inputs: `haddr` 32, `hwdata` 32, `hwrite` 1, `htrans` 2, `hsize` 3, `hburst` 3.
- Master-side outputs: `hrdata` 32, `hresp` 2, `hready` 1.
- `haddr_s`, `hwdata_s`, `hwrite_s`, `htrans_s`, `hsize_s`, `hburst_s` out: `[slave_c-1:0]` copies of the master signals (broadcast).
- `hrdata_s` in `[slave_c-1:0][31:0]`, `hresp_s` in `[slave_c-1:0][1:0]`, `hready_s` in `[slave_c-1:0]`: slave responses.
- `hsel_s` out `[slave_c-1:0]`: address-phase select.
- `hreadyin_s` out `[slave_c-1:0]`: master-side `hready` broadcast to the slaves.
- `hto_flag` out 1: sticky watchdog-fired flag.

## Operation
- **Decode.** `hit[i] = (haddr & ahb_mask[i]) == ahb_base[i]`.
  - Overlapping regions resolve to the lowest index.
  - `hsel_s` is the one-hot priority result, combinational, independent of `htrans`.
  - No hit selects the internal default slave (DS).
- **Data-phase select.** `sel_dp` is a `slave_c+1`-wide one-hot register.
  - It loads the decode result only when `hready` is 1 and holds while `hready` is 0.
  - Reset value is all-zero, which means "none".
- **Response mux.**
  - Real slave selected: `hrdata`, `hresp` and `hready` come from the selected slave.
  - "None" selected: `hrdata=0`, `hresp=OKAY`, `hready=1`.
  - DS selected: `hrdata=0`; `hresp` and `hready` come from the DS FSM.
- **DS FSM.** States `DS_IDLE`, `DS_ERR1`, `DS_ERR2`.
  - `DS_IDLE` → `DS_ERR1` when an unmapped transfer with `htrans` = NONSEQ/SEQ is accepted (`hready`=1).
  - Unmapped IDLE/BUSY transfers do not leave `DS_IDLE`; the data phase is zero-wait OKAY.
  - `DS_ERR1`: `hready=0`, `hresp=ERROR`; always advances to `DS_ERR2`.
  - `DS_ERR2`: `hready=1`, `hresp=ERROR`. Goes to `DS_ERR1` if another unmapped active transfer is accepted in this cycle, otherwise to `DS_IDLE`.
  - A mapped address accepted during `DS_ERR2` follows the normal path.
- **Encodings.** HRESP: OKAY=0, ERROR=1. HTRANS: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.

## Timing
- Decode to `hsel_s`: 0 cycles. `sel_dp`: 1 cycle after the address phase is accepted. Response mux: combinational from `sel_dp`.
- Unmapped active transfer: exactly 2 data-phase cycles (ERR1, ERR2). The next address phase is accepted in ERR2.
- Slave wait states are passed through unchanged. `sel_dp` is frozen while `hready`=0.
- **Reset values** (asynchronous, immediate, including mid-transfer):
  - `sel_dp`=0, DS FSM=`DS_IDLE`, watchdog counter=0, `hto_flag`=0.
  - Hence `hready`=1, `hresp`=OKAY, `hrdata`=0.
  - `hsel_s` still follows `haddr`.
- The bus is idle after reset release; no recovery cycle is needed.

## Configuration
- **`NF_AHB_ROUTER_TIMEOUT_EN` defined:**
  - A 16-bit counter increments each cycle a real slave is selected in `sel_dp` and its `hready_s` is 0. It clears when that `hready_s` is 1.
  - When the counter reaches `timeout_c`, the router overrides the slave for 2 cycles: `hready=0`/ERROR, then `hready=1`/ERROR.
  - During those 2 cycles `hreadyin_s` is 1 in the second cycle, so slaves see the transfer end.
  - `hto_flag` is set and stays set until reset. `sel_dp` reloads normally after the override.
- **Not defined:** no counter and no override; `hto_flag` is tied to 0.

## Structure
- Package `nf_ahb_pkg` holds:
  - the HTRANS/HRESP constants;
  - the DS FSM state enum;
  - `AHB_BASE_DEF`/`AHB_MASK_DEF`: RAM at 0x0000_0000, GPIO at 0x0001_0000, PWM at 0x0002_0000, UART at 0x0003_0000, all with mask 0xFFFF_0000.
- Sub-module `nf_ahb_dflt_slave` implements the DS FSM and, under the macro, the watchdog override sequencer.
- Decode, `sel_dp` and the response mux stay in the top module.

## Test plan
All tests use `slave_c`=4 with the default map.
- **Wait states.** Write to 0x0001_0004 with slave 1 holding `hready_s` low for 3 cycles → `hsel_s`=4'b0010 in the address phase; master `hready` low for 3 cycles; `sel_dp` is held through the wait.
- **Unmapped read.** NONSEQ read of 0x0005_0000 → next two cycles give `hready`=0/ERROR, then `hready`=1/ERROR; `hrdata`=0; no `hsel_s` bit is set.
- **Back-to-back unmapped.** Unmapped NONSEQ accepted in ERR2, followed by a mapped read of 0x0000_0010 → a second ERR1/ERR2 pair, then the RAM data is returned with OKAY.
- **Unmapped IDLE.** `htrans`=IDLE to 0x0005_0000 → zero-wait OKAY; the DS FSM stays in `DS_IDLE`.
- **Watchdog** (macro defined, `timeout_c`=8). Slave 2 stuck with `hready_s`=0 → ERROR pair starts after 8 wait cycles; `hto_flag`=1.
- **Reset mid-transfer.** `hresetn` asserted in the middle of a transfer → `hready`=1, `hresp`=OKAY and `hto_flag`=0 without waiting for a clock edge.
